regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_clr_fsm.sv | 58 +++++
 rtl/regfile_scoreboard.sv | 74 +++++++
 tb/tb_regfile_scoreboard.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file and its soft-clear sweep.
package regfile_pkg;

   localparam int unsigned DefaultXlen = 32;
   localparam int unsigned DefaultNreg = 32;

   typedef enum logic [0:0] {
      StIdle,
      StSweep
   } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback, issue and soft-clear signals between the pipeline and the register file.
interface regfile_scoreboard_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
);
   localparam int unsigned AW = $clog2(NREG);

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            iss_en;
   logic [AW-1:0]   iss_rd;
   logic            stall;
   logic            clr_start;
   logic            clr_busy;

   modport master (
      output wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, iss_en, iss_rd, clr_start,
      input  rs1_data, rs2_data, stall, clr_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, iss_en, iss_rd, clr_start,
      output rs1_data, rs2_data, stall, clr_busy
   );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: walks idx from 1 to NREG-1, one register per cycle.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned NREG = DefaultNreg,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_start_i,
   output logic          clr_busy_o,
   output logic [AW-1:0] idx_o
);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      clr_busy_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clr_start_i) begin
               state_d = StSweep;
               idx_d   = AW'(1);
            end
         end
         StSweep: begin
            clr_busy_o = 1'b1;
            // Last register cleared this cycle; park idx at 0 rather than wrapping.
            if (idx_q == AW'(NREG - 1)) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write bypass, per-register pending scoreboard and a soft-clear sweep.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN = DefaultXlen,
   parameter int unsigned NREG = DefaultNreg,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input logic                  clk,
   input logic                  reset,
   regfile_scoreboard_if.slave  bus
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic            clr_busy;
   logic [AW-1:0]   clr_idx;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            hit1, hit2;

   regfile_clr_fsm #(
      .NREG (NREG)
   ) u_clr_fsm (
      .clk         (clk),
      .reset       (reset),
      .clr_start_i (bus.clr_start),
      .clr_busy_o  (clr_busy),
      .idx_o       (clr_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
         busy_q <= busy_d;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NREG); i++) regs_d[i] = regs_q[i];
      busy_d = busy_q;
      if (clr_busy) begin
         regs_d[clr_idx] = '0;
         busy_d[clr_idx] = 1'b0;
      end else begin
         if (bus.wr_en && bus.wr_addr != '0) regs_d[bus.wr_addr] = bus.wr_data;
         if (bus.wr_en) busy_d[bus.wr_addr] = 1'b0;
         // Issue is applied after writeback so a new producer keeps the register pending.
         if (bus.iss_en && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign hit1 = bus.wr_en && (bus.wr_addr == bus.rs1_addr) && (bus.wr_addr != '0);
   assign hit2 = bus.wr_en && (bus.wr_addr == bus.rs2_addr) && (bus.wr_addr != '0);

   always_comb begin
      rs1_data = hit1 ? bus.wr_data : regs_q[bus.rs1_addr];
      rs2_data = hit2 ? bus.wr_data : regs_q[bus.rs2_addr];
      if (bus.rs1_addr == '0) rs1_data = '0;
      if (bus.rs2_addr == '0) rs2_data = '0;
   end

   assign bus.rs1_data = rs1_data;
   assign bus.rs2_data = rs2_data;
   assign bus.clr_busy = clr_busy;
   assign bus.stall    = clr_busy
                       | (busy_q[bus.rs1_addr] & ~(bus.wr_en & (bus.wr_addr == bus.rs1_addr)))
                       | (busy_q[bus.rs2_addr] & ~(bus.wr_en & (bus.wr_addr == bus.rs2_addr)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus pushes expected outputs into a queue, a negedge monitor checks them.
module tb_regfile_scoreboard;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;

   // mask bits: [0] rs1_data, [1] rs2_data, [2] stall, [3] clr_busy
   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        stall;
      logic        cb;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   exp_t   exp_q[$];
   string  name_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG)) rf_if ();

   regfile_scoreboard #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (rf_if)
   );

   always #5 clk = ~clk;

   // Monitor: checks every expectation issued for the current cycle.
   always @(negedge clk) begin
      exp_t  e;
      string n;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         if (e.mask[0]) begin
            n_tests++;
            if (rf_if.rs1_data !== e.rs1) begin
               n_fail++;
               $display("FAIL %s: rs1_data got %h want %h", n, rf_if.rs1_data, e.rs1);
            end
         end
         if (e.mask[1]) begin
            n_tests++;
            if (rf_if.rs2_data !== e.rs2) begin
               n_fail++;
               $display("FAIL %s: rs2_data got %h want %h", n, rf_if.rs2_data, e.rs2);
            end
         end
         if (e.mask[2]) begin
            n_tests++;
            if (rf_if.stall !== e.stall) begin
               n_fail++;
               $display("FAIL %s: stall got %b want %b", n, rf_if.stall, e.stall);
            end
         end
         if (e.mask[3]) begin
            n_tests++;
            if (rf_if.clr_busy !== e.cb) begin
               n_fail++;
               $display("FAIL %s: clr_busy got %b want %b", n, rf_if.clr_busy, e.cb);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string n, input logic [3:0] m, input logic [31:0] r1,
                             input logic [31:0] r2, input logic st, input logic cb);
      exp_t e;
      e.mask  = m;
      e.rs1   = r1;
      e.rs2   = r2;
      e.stall = st;
      e.cb    = cb;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic quiet();
      rf_if.wr_en     = 1'b0;
      rf_if.iss_en    = 1'b0;
      rf_if.clr_start = 1'b0;
   endtask

   task automatic set_rd(input int a1, input int a2);
      rf_if.rs1_addr = 5'(a1);
      rf_if.rs2_addr = 5'(a2);
   endtask

   task automatic write(input int a, input logic [31:0] d);
      rf_if.wr_en   = 1'b1;
      rf_if.wr_addr = 5'(a);
      rf_if.wr_data = d;
   endtask

   task automatic issue(input int a);
      rf_if.iss_en = 1'b1;
      rf_if.iss_rd = 5'(a);
   endtask

   task automatic fill_all();
      for (int i = 1; i < int'(NREG); i++) begin
         write(i, 32'hC000_0000 | 32'(i));
         cyc();
      end
      quiet();
   endtask

   task automatic check_all_zero(input string n);
      for (int i = 1; i < int'(NREG); i += 2) begin
         set_rd(i, (i + 1) % int'(NREG));
         expect_out(n, 4'b0111, 32'h0, 32'h0, 1'b0, 1'b0);
         cyc();
      end
   endtask

   initial begin
      reset = 1'b1;
      quiet();
      rf_if.wr_addr = '0;
      rf_if.wr_data = '0;
      rf_if.iss_rd  = '0;
      set_rd(0, 0);
      cyc();
      cyc();
      reset = 1'b0;

      set_rd(5, 7);
      expect_out("reset_state", 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();

      // Write r5, bypass in the same cycle, stored value next cycle.
      write(5, 32'hDEAD_BEEF);
      expect_out("r5_bypass", 4'b0001, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      cyc();
      quiet();
      expect_out("r5_read", 4'b0001, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      cyc();
      write(0, 32'h0000_1234);
      set_rd(0, 0);
      expect_out("r0_no_bypass", 4'b0011, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();
      quiet();
      expect_out("r0_reads_zero", 4'b0011, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();

      write(7, 32'hA5A5_A5A5);
      set_rd(5, 7);
      expect_out("r7_bypass", 4'b0011, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 1'b0, 1'b0);
      cyc();
      quiet();
      expect_out("r7_read", 4'b0010, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);
      cyc();

      // Issue r3: pending from the next cycle until writeback.
      issue(3);
      set_rd(3, 0);
      expect_out("issue_r3_same_cycle", 4'b0100, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();
      quiet();
      expect_out("r3_pending", 4'b0101, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc();
      write(3, 32'h0000_0033);
      expect_out("r3_writeback_cycle", 4'b0101, 32'h0000_0033, 32'h0, 1'b0, 1'b0);
      cyc();
      quiet();
      expect_out("r3_after_wb", 4'b0101, 32'h0000_0033, 32'h0, 1'b0, 1'b0);
      cyc();

      // Issue and writeback of r4 together: the new producer keeps it busy.
      issue(4);
      write(4, 32'h0000_0044);
      set_rd(0, 0);
      expect_out("r4_iss_wb_same", 4'b0100, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();
      quiet();
      set_rd(0, 4);
      expect_out("r4_still_busy", 4'b0110, 32'h0, 32'h0000_0044, 1'b1, 1'b0);
      cyc();
      write(4, 32'h0000_0045);
      expect_out("r4_wb_rs2", 4'b0110, 32'h0, 32'h0000_0045, 1'b0, 1'b0);
      cyc();
      quiet();
      issue(0);
      cyc();
      quiet();
      set_rd(0, 4);
      expect_out("r0_never_busy", 4'b0100, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();

      // Soft clear of a fully populated file, with writes/issues attempted mid-sweep.
      fill_all();
      issue(9);
      set_rd(31, 1);
      expect_out("filled", 4'b0011, 32'hC000_001F, 32'hC000_0001, 1'b0, 1'b0);
      cyc();
      quiet();
      rf_if.clr_start = 1'b1;
      set_rd(9, 0);
      expect_out("clr_start_cycle", 4'b1100, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc();
      for (int k = 1; k < int'(NREG); k++) begin
         write(2, 32'h0000_0BAD);
         issue(5);
         rf_if.clr_start = 1'b1;
         set_rd(0, 0);
         expect_out("sweep_busy", 4'b1100, 32'h0, 32'h0, 1'b1, 1'b1);
         cyc();
      end
      quiet();
      set_rd(2, 5);
      expect_out("sweep_done", 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();
      check_all_zero("post_sweep_zero");

      // Reset during a sweep aborts it.
      fill_all();
      issue(20);
      cyc();
      quiet();
      rf_if.clr_start = 1'b1;
      cyc();
      rf_if.clr_start = 1'b0;
      for (int k = 1; k < 10; k++) begin
         expect_out("sweep_pre_reset", 4'b1000, 32'h0, 32'h0, 1'b0, 1'b1);
         cyc();
      end
      reset = 1'b1;
      expect_out("sweep_cycle10", 4'b1000, 32'h0, 32'h0, 1'b0, 1'b1);
      cyc();
      reset = 1'b0;
      set_rd(20, 31);
      expect_out("reset_abort", 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc();
      check_all_zero("post_reset_zero");
      write(12, 32'h0000_0077);
      cyc();
      quiet();
      set_rd(12, 0);
      expect_out("write_after_abort", 4'b1101, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
      cyc();

      cyc();
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL queue_drain: pending %0d want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
